// File: rtl/arbmux_if.sv
// Handshake bundle between requesters, the arbitrating mux and its consumer.
// Master drives requests and downstream ready; slave is the arbiter.
interface arbmux_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                         arb_flush;
  logic [NUM_CH-1:0]            arb_req_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] arb_req_data;
  logic [NUM_CH-1:0]            arb_req_ready;
  logic                         arb_out_valid;
  logic [DATA_WIDTH-1:0]        arb_out_data;
  logic [NUM_CH-1:0]            arb_out_grant;
  logic [CH_W-1:0]              arb_out_chan;
  logic                         arb_out_ready;

  modport master (
    output arb_flush, arb_req_valid, arb_req_data, arb_out_ready,
    input  arb_req_ready, arb_out_valid, arb_out_data,
    input  arb_out_grant, arb_out_chan
  );

  modport slave (
    input  arb_flush, arb_req_valid, arb_req_data, arb_out_ready,
    output arb_req_ready, arb_out_valid, arb_out_data,
    output arb_out_grant, arb_out_chan
  );
endinterface

// File: rtl/arbmux_module.sv
// N-channel arbitrating mux (fixed priority or round-robin) feeding
// a single-entry registered output stage.
module arbmux_module #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int ARB_MODE   = 0
) (
  input logic     clk,
  input logic     rst,
  arbmux_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NUM_CH-1:0]     r_grant;
  logic [CH_W-1:0]       r_chan;
  logic [CH_W-1:0]       r_rr_ptr;

  logic                  w_load;
  logic                  w_any;
  logic [CH_W-1:0]       w_base;
  logic [CH_W-1:0]       w_win;
  logic [NUM_CH-1:0]     w_onehot;
  logic [CH_W-1:0]       w_ptr_nxt;
  logic [DATA_WIDTH-1:0] w_data [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_data[g] = bus.arb_req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_load = (~r_valid | bus.arb_out_ready) & ~bus.arb_flush;
  assign w_any  = |bus.arb_req_valid;
  assign w_base = (ARB_MODE == 1) ? r_rr_ptr : '0;

  // Scan from the far end so the nearest valid channel to w_base wins.
  always_comb begin
    int w_idx;
    w_idx = 0;
    w_win = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_idx = int'(w_base) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (bus.arb_req_valid[w_idx[CH_W-1:0]]) w_win = w_idx[CH_W-1:0];
    end
  end

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_win] = 1'b1;
  end

  assign w_ptr_nxt = (w_win == CH_W'(NUM_CH - 1)) ? '0 : w_win + 1'b1;

  assign bus.arb_req_ready = (w_load & w_any & ~rst) ? w_onehot : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_grant  <= '0;
      r_chan   <= '0;
      r_rr_ptr <= '0;
    end else if (bus.arb_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data   <= w_data[w_win];
        r_grant  <= w_onehot;
        r_chan   <= w_win;
        r_rr_ptr <= w_ptr_nxt;
      end
    end
  end

  assign bus.arb_out_valid = r_valid;
  assign bus.arb_out_data  = r_data;
  assign bus.arb_out_grant = r_grant;
  assign bus.arb_out_chan  = r_chan;
endmodule

// File: tb/tb_arbmux_module.sv
// Self-checking bench: fixed-priority x4, round-robin x4 and round-robin x3
// instances driven in lockstep and compared against a behavioural model.
module tb_arbmux_module;
  logic clk;
  logic rst;
  logic fl;
  logic ordy;
  logic [3:0]  v [3];
  logic [31:0] d [3][4];

  int checks = 0;
  int errors = 0;

  int mode [3] = '{0, 1, 1};
  int nch  [3] = '{4, 4, 3};

  bit          m_v [3];
  logic [31:0] m_d [3];
  int          m_c [3];
  logic [3:0]  m_g [3];
  int          m_p [3];

  logic [3:0]  rdy [3];
  logic        ov  [3];
  logic [31:0] od  [3];
  logic [3:0]  og  [3];
  logic [1:0]  oc  [3];

  arbmux_if #(.DATA_WIDTH(32), .NUM_CH(4)) i0 ();
  arbmux_if #(.DATA_WIDTH(32), .NUM_CH(4)) i1 ();
  arbmux_if #(.DATA_WIDTH(32), .NUM_CH(3)) i2 ();

  arbmux_module #(.DATA_WIDTH(32), .NUM_CH(4), .ARB_MODE(0)) u0 (
    .clk(clk), .rst(rst), .bus(i0));
  arbmux_module #(.DATA_WIDTH(32), .NUM_CH(4), .ARB_MODE(1)) u1 (
    .clk(clk), .rst(rst), .bus(i1));
  arbmux_module #(.DATA_WIDTH(32), .NUM_CH(3), .ARB_MODE(1)) u2 (
    .clk(clk), .rst(rst), .bus(i2));

  assign i0.arb_flush = fl;
  assign i1.arb_flush = fl;
  assign i2.arb_flush = fl;
  assign i0.arb_out_ready = ordy;
  assign i1.arb_out_ready = ordy;
  assign i2.arb_out_ready = ordy;
  assign i0.arb_req_valid = v[0];
  assign i1.arb_req_valid = v[1];
  assign i2.arb_req_valid = v[2][2:0];
  assign i0.arb_req_data = {d[0][3], d[0][2], d[0][1], d[0][0]};
  assign i1.arb_req_data = {d[1][3], d[1][2], d[1][1], d[1][0]};
  assign i2.arb_req_data = {d[2][2], d[2][1], d[2][0]};

  assign rdy[0] = i0.arb_req_ready;
  assign rdy[1] = i1.arb_req_ready;
  assign rdy[2] = {1'b0, i2.arb_req_ready};
  assign ov[0] = i0.arb_out_valid;
  assign ov[1] = i1.arb_out_valid;
  assign ov[2] = i2.arb_out_valid;
  assign od[0] = i0.arb_out_data;
  assign od[1] = i1.arb_out_data;
  assign od[2] = i2.arb_out_data;
  assign og[0] = i0.arb_out_grant;
  assign og[1] = i1.arb_out_grant;
  assign og[2] = {1'b0, i2.arb_out_grant};
  assign oc[0] = i0.arb_out_chan;
  assign oc[1] = i1.arb_out_chan;
  assign oc[2] = i2.arb_out_chan;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Winner = first valid channel in search order starting at the pointer.
  function automatic int pick(int k, logic [3:0] vv);
    int base;
    int c;
    base = (mode[k] == 1) ? m_p[k] : 0;
    for (int j = 0; j < nch[k]; j++) begin
      c = (base + j) % nch[k];
      if (vv[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_all(logic [3:0] vv, logic r, logic f);
    for (int k = 0; k < 3; k++) v[k] = vv;
    ordy = r;
    fl   = f;
  endtask

  task automatic check_outs(string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s d%0d valid", tag, k), 32'(ov[k]), 32'(m_v[k]));
      chk($sformatf("%s d%0d data", tag, k), od[k], m_d[k]);
      chk($sformatf("%s d%0d chan", tag, k), 32'(oc[k]), m_c[k]);
      chk($sformatf("%s d%0d grant", tag, k), 32'(og[k]), 32'(m_g[k]));
    end
  endtask

  task automatic cycle(string tag, bit keep = 0);
    int w [3];
    bit ld [3];
    if (!keep)
      for (int k = 0; k < 3; k++)
        for (int c = 0; c < 4; c++) d[k][c] = $urandom;
    #1;
    for (int k = 0; k < 3; k++) begin
      ld[k] = (!m_v[k] || ordy) && !fl;
      w[k]  = pick(k, v[k]);
      chk($sformatf("%s d%0d ready", tag, k), 32'(rdy[k]),
          (!rst && ld[k] && w[k] >= 0) ? (32'd1 << w[k]) : 32'd0);
    end
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (fl) m_v[k] = 1'b0;
        else if (ld[k]) begin
          if (w[k] >= 0) begin
            m_v[k] = 1'b1;
            m_d[k] = d[k][w[k]];
            m_c[k] = w[k];
            m_g[k] = 4'(1 << w[k]);
            if (mode[k] == 1) m_p[k] = (w[k] + 1) % nch[k];
          end else m_v[k] = 1'b0;
        end
      end
    end
    #1;
    check_outs(tag);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0; m_d[k] = '0; m_c[k] = 0; m_g[k] = '0; m_p[k] = 0;
      chk($sformatf("%s d%0d ready", tag, k), 32'(rdy[k]), 32'd0);
    end
    check_outs(tag);
    cycle(tag);
    rst = 1'b0;
  endtask

  initial begin
    int exp_rr4 [5] = '{0, 1, 2, 3, 0};
    int exp_rr3 [4] = '{0, 2, 0, 2};
    rst = 1'b1;
    set_all(4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      m_v[k] = 1'b0; m_d[k] = '0; m_c[k] = 0; m_g[k] = '0; m_p[k] = 0;
      for (int c = 0; c < 4; c++) d[k][c] = '0;
    end
    cycle("por");
    cycle("por");
    rst = 1'b0;

    // load something, hold it, then reset mid-cycle
    set_all(4'b0110, 1'b0, 1'b0);
    cycle("pre_rst");
    chk("pre_rst inflight", 32'(ov[0]), 32'd1);
    do_reset("rst_mid");
    set_all(4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) d[k][0] = 32'hA5A5_0000;
    cycle("rst_rel", 1);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rel d%0d data", k), od[k], 32'hA5A5_0000);
      chk($sformatf("rst_rel d%0d chan", k), 32'(oc[k]), 32'd0);
      chk($sformatf("rst_rel d%0d grant", k), 32'(og[k]), 32'd1);
    end

    // fixed priority: channel 1 always beats channel 3
    set_all(4'b1010, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle("fixed");
      chk("fixed chan", 32'(oc[0]), 32'd1);
      chk("fixed grant", 32'(og[0]), 32'b0010);
    end

    // round-robin full rotation
    do_reset("rst_rr");
    set_all(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle("rr4");
      chk("rr4 seq", 32'(oc[1]), exp_rr4[i]);
    end

    // wrap at a non-power-of-two channel count
    do_reset("rst_rr3");
    set_all(4'b0101, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle("rr3");
      chk("rr3 seq", 32'(oc[2]), exp_rr3[i]);
    end

    // backpressure then drain with refill
    set_all(4'b0100, 1'b1, 1'b0);
    cycle("bp_load");
    ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle("bp_hold");
      chk("bp_hold rdy0", 32'(rdy[0]), 32'd0);
    end
    ordy = 1'b1;
    cycle("bp_rel");
    chk("bp_rel valid", 32'(ov[0]), 32'd1);
    chk("bp_rel data", od[0], d[0][2]);

    // flush with pending request and blocked output
    set_all(4'b1111, 1'b0, 1'b1);
    cycle("flush");
    chk("flush valid", 32'(ov[1]), 32'd0);
    set_all(4'b1111, 1'b1, 1'b0);
    cycle("post_flush");
    chk("post_flush rr ptr", 32'(oc[1]), 32'd3);

    // idle drain keeps data/chan
    set_all(4'b0010, 1'b1, 1'b0);
    cycle("idle_ld");
    set_all(4'b0000, 1'b1, 1'b0);
    cycle("idle");
    chk("idle valid", 32'(ov[0]), 32'd0);
    chk("idle chan", 32'(oc[0]), 32'd1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_all(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) == 0));
      if (i == 200) do_reset("rnd_rst");
      else cycle("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbmux_module.md
# arbmux_module

Parametrised N-channel arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel. It generalises the one-hot priority mux from a fixed 4:1 combinational select to NUM_CH requesters. Arbitration is either fixed-priority or round-robin, and the grant is held in a pipeline register. It sits wherever several producers share one consumer, for example issue-queue ports to a functional unit or multiple fetch/LSU requesters to a bus port.

## Interface
- DATA_WIDTH, 32, payload width per channel
- NUM_CH, 4, number of requesting channels, ≥2
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- CH_W (localparam), $clog2(NUM_CH), channel index width
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- arb_flush  input  1  synchronous clear of the output stage
- arb_req_valid  input  NUM_CH  per-channel request valid
- arb_req_data  input  NUM_CH*DATA_WIDTH  packed payloads; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- arb_req_ready  output  NUM_CH  per-channel accept; one-hot or zero
- arb_out_valid  output  1  registered output valid
- arb_out_data  output  DATA_WIDTH  registered payload
- arb_out_grant  output  NUM_CH  registered one-hot of the source channel
- arb_out_chan  output  CH_W  registered binary index of the source channel
- arb_out_ready  input  1  downstream accept

## Operation
- Output stage capacity: 1 entry. `load = (~arb_out_valid | arb_out_ready) & ~arb_flush`.
- Arbitration is combinational over `arb_req_valid`. The winner is w. `arb_req_ready[w] = load & |arb_req_valid`; every other ready bit is 0.
- A transfer on channel i occurs when `arb_req_valid[i] & arb_req_ready[i]`. On that edge the output registers take data[i], one-hot(i), index i, and `valid = 1`.
- If `load` is set and no request is valid, `arb_out_valid` goes to 0 on the edge, and the data/grant/chan registers hold their value.
- If `load` is clear, all output registers hold.
- ARB_MODE=0: w is the lowest set index. Starvation of high indices is permitted.
- ARB_MODE=1:
  - A pointer register `rr_ptr[CH_W-1:0]` marks the highest-priority channel.
  - Search order is rr_ptr, rr_ptr+1, …, NUM_CH-1, 0, …, rr_ptr-1 (wraps modulo NUM_CH; NUM_CH need not be a power of two).
  - After a transfer from channel w, `rr_ptr` becomes (w+1) mod NUM_CH.
  - `rr_ptr` changes only on a transfer.
- `arb_flush`:
  - Next edge: `arb_out_valid` becomes 0.
  - No transfer that cycle: all ready outputs are 0.
  - `rr_ptr` is unchanged.
  - Flush overrides `arb_out_ready` and any pending load.
- A requester may drop or change valid/data at any time before its transfer. The block has no lock or hold state.

## Timing
- Reset values:
  - `arb_out_valid = 0`
  - `arb_out_data = 0`
  - `arb_out_grant = 0`
  - `arb_out_chan = 0`
  - `rr_ptr = 0`
  - `arb_req_ready` is 0 while rst is asserted.
- Reset asserted mid-transfer: an in-flight output is discarded immediately (asynchronous). No request is accepted while rst is high.
- Latency: request accepted on edge N, visible at `arb_out_*` after edge N. One cycle.
- Throughput: one transfer per cycle when `arb_out_ready` is held high.
- Combinational paths:
  - `arb_req_ready` depends combinationally on `arb_out_ready`, `arb_out_valid`, `arb_flush`, `arb_req_valid` and `rr_ptr`.
  - No path from `arb_req_valid` to `arb_out_*`.
- Backpressure: with `arb_out_valid = 1` and `arb_out_ready = 0`, the outputs are stable and all `arb_req_ready` bits are 0.
- Simultaneous drain and refill: `arb_out_valid = 1`, `arb_out_ready = 1` and a pending request cause a new entry to load on the same edge. Valid stays 1 with no bubble.

## Test plan
- **Reset.** Assert rst mid-cycle while `arb_out_valid = 1` → all outputs are 0 immediately and `arb_req_ready = 0`. Release rst with valid = 4'b0001 and data0 = 32'hA5A5_0000 → after one edge, out_data = A5A5_0000, chan = 0, grant = 4'b0001.
- **Fixed priority (ARB_MODE=0, NUM_CH=4).** valid = 4'b1010 held high, out_ready = 1 for 3 cycles → channel 1 is granted every cycle and channel 3 never.
- **Round-robin (ARB_MODE=1, NUM_CH=4).** valid = 4'b1111 held high, out_ready = 1 → chan sequence 0, 1, 2, 3, 0. Then with NUM_CH=3, valid = 3'b101 → sequence 0, 2, 0, 2 (wrap at a non-power-of-two count).
- **Backpressure.** Hold out_ready = 0 for 5 cycles with valid = 4'b0100 → out_* stable, ready = 0 throughout. Raise out_ready → channel 2's next item loads on the same edge the old one drains, with no bubble.
- **Flush.** Assert arb_flush with out_valid = 1, out_ready = 0 and a pending request → next edge out_valid = 0, no req handshake, rr_ptr unchanged. The next grant follows the prior pointer.
- **Idle drain.** out_valid = 1, out_ready = 1, valid = 0 → out_valid falls to 0, and data/chan hold their previous values.
